// File: rtl/param_pipelined_barrel_shifter.sv
// Width-parametrised barrel shifter, one register stage per shift-amount bit, valid/ready flow.
// Optional carry_out output enabled by defining BSHIFT_CARRY_EN.
module param_pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       operation,
  input  logic [SHW-1:0]   number_of_positions,
  input  logic             direction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSHIFT_CARRY_EN
  ,
  output logic             carry_out
`endif
);

  typedef enum logic [1:0] {
    OpStore  = 2'd0,
    OpRotate = 2'd1,
    OpLogic  = 2'd2,
    OpArith  = 2'd3
  } op_e;

  logic advance;

  // Stage registers
  logic [WIDTH-1:0] data_q  [SHW];
  op_e              op_q    [SHW];
  logic [SHW-1:0]   amt_q   [SHW];
  logic             dir_q   [SHW];
  logic             fill_q  [SHW];
  logic             valid_q [SHW];

  // Stage inputs: index 0 is the accepted beat, index k is the output of stage k-1
  logic [WIDTH-1:0] st_data  [SHW];
  op_e              st_op    [SHW];
  logic [SHW-1:0]   st_amt   [SHW];
  logic             st_dir   [SHW];
  logic             st_fill  [SHW];
  logic             st_valid [SHW];

  logic [WIDTH-1:0] data_d   [SHW];

`ifdef BSHIFT_CARRY_EN
  logic           carry_q  [SHW];
  logic           st_carry [SHW];
  logic           carry_in;
  logic [SHW-1:0] carry_idx;

  // Shifted-out bit is known at accept; rotates pick the same source bit.
  always_comb begin
    carry_idx = '0;
    carry_in  = 1'b0;
    if (operation != OpStore && number_of_positions != '0) begin
      carry_idx = direction ? number_of_positions - SHW'(1) : SHW'(0) - number_of_positions;
      carry_in  = in_data[carry_idx];
    end
  end
`endif

  assign advance   = !valid_q[SHW-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
`ifdef BSHIFT_CARRY_EN
  assign carry_out = carry_q[SHW-1];
`endif

  always_comb begin : stage_inputs
    st_data[0]  = in_data;
    st_op[0]    = op_e'(operation);
    st_amt[0]   = number_of_positions;
    st_dir[0]   = direction;
    // Arithmetic right fill is latched once so later stages never see a shifted sign bit.
    st_fill[0]  = (operation == OpArith) && in_data[WIDTH-1];
    st_valid[0] = in_valid;
`ifdef BSHIFT_CARRY_EN
    st_carry[0] = carry_in;
`endif
    for (int k = 1; k < SHW; k++) begin
      st_data[k]  = data_q[k-1];
      st_op[k]    = op_q[k-1];
      st_amt[k]   = amt_q[k-1];
      st_dir[k]   = dir_q[k-1];
      st_fill[k]  = fill_q[k-1];
      st_valid[k] = valid_q[k-1];
`ifdef BSHIFT_CARRY_EN
      st_carry[k] = carry_q[k-1];
`endif
    end
  end

  always_comb begin : stage_shift
    logic [WIDTH-1:0] res;
    for (int k = 0; k < SHW; k++) begin
      res = st_data[k];
      if (st_amt[k][k] && st_op[k] != OpStore) begin
        if (!st_dir[k]) begin
          res = st_data[k] << (1 << k);
          if (st_op[k] == OpRotate) begin
            res = res | (st_data[k] >> (WIDTH - (1 << k)));
          end
        end else begin
          res = st_data[k] >> (1 << k);
          if (st_op[k] == OpRotate) begin
            res = res | (st_data[k] << (WIDTH - (1 << k)));
          end else if (st_fill[k]) begin
            res = res | ~({WIDTH{1'b1}} >> (1 << k));
          end
        end
      end
      data_d[k] = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        op_q[k]    <= OpStore;
        amt_q[k]   <= '0;
        dir_q[k]   <= 1'b0;
        fill_q[k]  <= 1'b0;
        valid_q[k] <= 1'b0;
`ifdef BSHIFT_CARRY_EN
        carry_q[k] <= 1'b0;
`endif
      end
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= data_d[k];
        op_q[k]    <= st_op[k];
        amt_q[k]   <= st_amt[k];
        dir_q[k]   <= st_dir[k];
        fill_q[k]  <= st_fill[k];
        valid_q[k] <= st_valid[k];
`ifdef BSHIFT_CARRY_EN
        carry_q[k] <= st_carry[k];
`endif
      end
    end
  end

  // Control fields of the last stage are carried for uniformity but not consumed.
  logic unused_ctrl;
  always_comb begin
    unused_ctrl = ^{op_q[SHW-1], dir_q[SHW-1], fill_q[SHW-1]};
    for (int k = 0; k < SHW; k++) begin
      unused_ctrl = unused_ctrl ^ (^amt_q[k]);
    end
  end

endmodule

// File: tb/tb_param_pipelined_barrel_shifter.sv
// Randomised and directed bench for param_pipelined_barrel_shifter (WIDTH=8, latency 3).
module tb_param_pipelined_barrel_shifter;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] operation = '0;
  logic [2:0] number_of_positions = '0;
  logic       direction = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
`ifdef BSHIFT_CARRY_EN
  logic       carry_out;
`endif

  always #5 clk = ~clk;

  param_pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .operation           (operation),
    .number_of_positions (number_of_positions),
    .direction           (direction),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data)
`ifdef BSHIFT_CARRY_EN
    ,
    .carry_out           (carry_out)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       carry;
    int         cyc;
    int         stalls;
    bit         has_const;
    logic [7:0] cdata;
    bit         has_cc;
    logic       ccarry;
  } beat_t;

  beat_t      exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         stalls = 0;
  int         rdy_mode = 0;
  bit         k_has = 0;
  logic [7:0] k_data = '0;
  bit         k_hasc = 0;
  logic       k_carry = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-amount shifts straight from the operation definitions.
  function automatic logic [8:0] model(input logic [7:0] d, input logic [1:0] op, input int n,
                                       input logic dir);
    logic [7:0] r;
    logic [7:0] t;
    logic       c;
    r = d;
    c = 1'b0;
    if (n != 0) begin
      case (op)
        2'd1: begin
          r = dir ? ((d >> n) | (d << (8 - n))) : ((d << n) | (d >> (8 - n)));
          c = dir ? r[7] : r[0];
        end
        2'd2, 2'd3: begin
          if (!dir) r = d << n;
          else if (op == 2'd3) r = $signed(d) >>> n;
          else r = d >> n;
          t = dir ? (d >> (n - 1)) : (d >> (8 - n));
          c = t[0];
        end
        default: ;
      endcase
    end
    return {c, r};
  endfunction

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    beat_t      b;
    logic [8:0] m;
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", out_valid, 0);
        end else begin
          b = exp_q.pop_front();
          check_eq("data", out_data, b.data);
          check_eq("latency", cyc - b.cyc, LAT + stalls - b.stalls);
          if (b.has_const) check_eq("spec_data", out_data, b.cdata);
`ifdef BSHIFT_CARRY_EN
          check_eq("carry", carry_out, b.carry);
          if (b.has_cc) check_eq("spec_carry", carry_out, b.ccarry);
`endif
        end
      end else if (out_valid) begin
        stalls++;
        check_eq("stall_in_ready", in_ready, 0);
        if (exp_q.size() > 0) check_eq("stall_data", out_data, exp_q[0].data);
      end
      if (in_valid && in_ready) begin
        m = model(in_data, operation, number_of_positions, direction);
        b.data      = m[7:0];
        b.carry     = m[8];
        b.cyc       = cyc;
        b.stalls    = stalls;
        b.has_const = k_has;
        b.cdata     = k_data;
        b.has_cc    = k_hasc;
        b.ccarry    = k_carry;
        exp_q.push_back(b);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] op, input logic [2:0] n,
                      input logic dir, input bit hc = 0, input logic [7:0] cd = '0,
                      input bit hcc = 0, input logic cc = 1'b0);
    bit got;
    int guard;
    in_valid            = 1'b1;
    in_data             = d;
    operation           = op;
    number_of_positions = n;
    direction           = dir;
    k_has               = hc;
    k_data              = cd;
    k_hasc              = hcc;
    k_carry             = cc;
    got                 = 0;
    guard               = 0;
    while (!got) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 1000) begin
        $display("FAIL send_timeout: got no accept expected accept within 1000 cycles");
        $fatal(1, "send timed out");
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    k_has    = 0;
    k_hasc   = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rand();
    send(8'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [7:0] d;
    int         guard;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", in_ready, 1);

    send(8'hDA, 2'd1, 3'd2, 1'b1, 1, 8'hB6, 1, 1'b1);
    idle(6);

    // Back-to-back beats
    send(8'hDA, 2'd3, 3'd2, 1'b1, 1, 8'hF6);
    send(8'hDA, 2'd1, 3'd3, 1'b0, 1, 8'hD6);
    send(8'hDA, 2'd2, 3'd2, 1'b0, 1, 8'h68, 1, 1'b1);
    send(8'hFF, 2'd1, 3'd2, 1'b1, 1, 8'hFF);
    send(8'hAA, 2'd0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1, 8'hAA);
    idle(6);

    // Boundaries
    send(8'h80, 2'd3, 3'd7, 1'b1, 1, 8'hFF);
    send(8'h80, 2'd2, 3'd7, 1'b1, 1, 8'h01);
    send(8'h01, 2'd1, 3'd7, 1'b0, 1, 8'h80);
    for (int op = 0; op < 4; op++) begin
      d = 8'($urandom);
      send(d, 2'(op), 3'd0, 1'($urandom_range(0, 1)), 1, d, 1, 1'b0);
    end
    idle(6);

    // Bubbles
    send_rand();
    idle(1);
    send_rand();
    idle(6);

    // Backpressure
    rdy_mode = 2;
    idle(1);
    repeat (3) send_rand();
    idle(5);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    rdy_mode = 0;
    idle(8);

    // Reset with beats in flight
    repeat (3) send_rand();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_data", out_data, 0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_midrst", in_ready, 1);
    send(8'hDA, 2'd1, 3'd2, 1'b1, 1, 8'hB6, 1, 1'b1);
    idle(6);

    // Random traffic with random backpressure
    rdy_mode = 1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_rand();
    end
    idle(1);
    rdy_mode = 0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      idle(1);
      guard++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
